// File: rtl/zx_video_pkg.sv
// Shared video definitions for the ZX pixel colorizer: intensity levels,
// attribute and colour-index bit positions, and the 5:6:5 pixel type.
package zx_video_pkg;

  localparam logic [4:0] LVL_N_DEF = 5'h14;
  localparam logic [4:0] LVL_B_DEF = 5'h1F;

  localparam int unsigned ATTR_INK_LSB   = 0;
  localparam int unsigned ATTR_PAPER_LSB = 3;
  localparam int unsigned ATTR_BRIGHT    = 6;
  localparam int unsigned ATTR_FLASH     = 7;

  localparam int unsigned CIDX_B = 0;
  localparam int unsigned CIDX_R = 1;
  localparam int unsigned CIDX_G = 2;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/zx_palette.sv
// Combinational {G,R,B} colour index + bright to 5:6:5 RGB.
module zx_palette
  import zx_video_pkg::*;
#(
  parameter logic [4:0] LVL_N = LVL_N_DEF,
  parameter logic [4:0] LVL_B = LVL_B_DEF
) (
  input  logic [2:0] idx,
  input  logic       bright,
  output rgb565_t    rgb
);

  logic [4:0] lvl5;
  logic [5:0] lvl6;

  always_comb begin
    lvl5  = bright ? LVL_B : LVL_N;
    lvl6  = bright ? {LVL_B, 1'b1} : {LVL_N, 1'b0};
    rgb.r = idx[CIDX_R] ? lvl5 : '0;
    rgb.g = idx[CIDX_G] ? lvl6 : '0;
    rgb.b = idx[CIDX_B] ? lvl5 : '0;
  end

endmodule

// File: rtl/zx_pixel_colorizer.sv
// Pixel shifter, attribute colouring, border/blanking mux and sync delay.
// Optional macro VIDEO_SCANLINE_EN halves intensity on alternate lines.
module zx_pixel_colorizer
  import zx_video_pkg::*;
#(
  parameter logic [4:0]  LVL_N      = LVL_N_DEF,
  parameter logic [4:0]  LVL_B      = LVL_B_DEF,
  parameter int unsigned FLASH_BITS = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] bits_in,
  input  logic [7:0] attr_in,
  input  logic       paper_en,
  input  logic       visible,
  input  logic [2:0] border,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [4:0] r,
  output logic [5:0] g,
  output logic [4:0] b,
  output logic       hs,
  output logic       vs
);

  logic [7:0]            sreg;
  logic [7:0]            areg;
  logic                  phase;
  logic [FLASH_BITS-1:0] frame_cnt;
  logic                  vs_prev;
  logic                  flash_phase;
  logic [2:0]            ink;
  logic [2:0]            paper;
  logic [2:0]            pix_idx;
  rgb565_t               pix_rgb;
  rgb565_t               bord_rgb;
  rgb565_t               next_rgb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg  <= '0;
      areg  <= '0;
      phase <= 1'b0;
    end else if (load) begin
      sreg  <= bits_in;
      areg  <= attr_in;
      phase <= 1'b0;
    end else begin
      if (phase) sreg <= {sreg[6:0], 1'b0};
      phase <= ~phase;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_prev <= vs_in;
      if (vs_in && !vs_prev) frame_cnt <= frame_cnt + FLASH_BITS'(1);
    end
  end

  always_comb begin
    flash_phase = frame_cnt[FLASH_BITS-1];
    ink         = areg[ATTR_INK_LSB +: 3];
    paper       = areg[ATTR_PAPER_LSB +: 3];
    // Flash is a swap of ink/paper, equivalent to inverting the selected pixel.
    pix_idx     = (sreg[7] ^ (areg[ATTR_FLASH] & flash_phase)) ? ink : paper;
  end

  zx_palette #(.LVL_N(LVL_N), .LVL_B(LVL_B)) u_pix_pal (
    .idx    (pix_idx),
    .bright (areg[ATTR_BRIGHT]),
    .rgb    (pix_rgb)
  );

  zx_palette #(.LVL_N(LVL_N), .LVL_B(LVL_B)) u_bord_pal (
    .idx    (border),
    .bright (1'b0),
    .rgb    (bord_rgb)
  );

`ifdef VIDEO_SCANLINE_EN
  logic hs_prev;
  logic parity;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev <= 1'b0;
      parity  <= 1'b0;
    end else begin
      hs_prev <= hs_in;
      if (vs_in && !vs_prev)      parity <= 1'b0;
      else if (hs_in && !hs_prev) parity <= ~parity;
    end
  end
`endif

  always_comb begin
    if (!visible)      next_rgb = '0;
    else if (!paper_en) next_rgb = bord_rgb;
    else               next_rgb = pix_rgb;
`ifdef VIDEO_SCANLINE_EN
    if (parity) begin
      next_rgb.r = next_rgb.r >> 1;
      next_rgb.g = next_rgb.g >> 1;
      next_rgb.b = next_rgb.b >> 1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      hs <= 1'b0;
      vs <= 1'b0;
    end else begin
      r  <= next_rgb.r;
      g  <= next_rgb.g;
      b  <= next_rgb.b;
      hs <= hs_in;
      vs <= vs_in;
    end
  end

endmodule

// File: tb/tb_zx_pixel_colorizer.sv
// Self-checking bench for zx_pixel_colorizer against a pixel-age/frame-count model.
module tb_zx_pixel_colorizer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] bits_in;
  logic [7:0] attr_in;
  logic       paper_en;
  logic       visible;
  logic [2:0] border;
  logic       hs_in;
  logic       vs_in;
  logic [4:0] r;
  logic [5:0] g;
  logic [4:0] b;
  logic       hs;
  logic       vs;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: last loaded byte/attr, clocks since load, vs rises since reset.
  logic [7:0]  m_byte;
  logic [7:0]  m_attr;
  int unsigned m_age;
  int unsigned m_frames;
  logic        m_vs_last;
  logic        m_hs_last;
  logic        m_par;

  zx_pixel_colorizer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .bits_in  (bits_in),
    .attr_in  (attr_in),
    .paper_en (paper_en),
    .visible  (visible),
    .border   (border),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .r        (r),
    .g        (g),
    .b        (b),
    .hs       (hs),
    .vs       (vs)
  );

  always #20 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rgb(input logic vis, input logic pen,
                                          input logic [2:0] bord,
                                          input logic [7:0] byt, input logic [7:0] attr,
                                          input int unsigned ag, input int unsigned fr,
                                          input logic par);
    int unsigned idx;
    logic        pix;
    logic        br;
    logic [2:0]  ci;
    logic [2:0]  ink;
    logic [2:0]  pap;
    int          rr, gg, bb;
    if (!vis) return 16'h0;
    if (!pen) begin
      ci = bord;
      br = 1'b0;
    end else begin
      idx = ag / 2;
      pix = (idx < 8) ? byt[7 - idx] : 1'b0;
      ink = attr[2:0];
      pap = attr[5:3];
      if (attr[7] && ((fr / 16) % 2 == 1)) begin
        ink = attr[5:3];
        pap = attr[2:0];
      end
      ci = pix ? ink : pap;
      br = attr[6];
    end
    rr = ci[1] ? (br ? 31 : 20) : 0;
    gg = ci[2] ? (br ? 63 : 40) : 0;
    bb = ci[0] ? (br ? 31 : 20) : 0;
    if (par) begin
      rr = rr / 2;
      gg = gg / 2;
      bb = bb / 2;
    end
    return {rr[4:0], gg[5:0], bb[4:0]};
  endfunction

  task automatic model_reset();
    m_byte    = 8'h00;
    m_attr    = 8'h00;
    m_age     = 16;
    m_frames  = 0;
    m_vs_last = 1'b0;
    m_hs_last = 1'b0;
    m_par     = 1'b0;
  endtask

  // One clock: predict from current inputs, clock, compare, advance model.
  task automatic step();
    logic [15:0] e;
    logic        eh, ev;
    logic        vs_rise, hs_rise;
    if (!reset_n) begin
      e  = 16'h0;
      eh = 1'b0;
      ev = 1'b0;
    end else begin
      e  = ref_rgb(visible, paper_en, border, m_byte, m_attr, m_age, m_frames, m_par);
      eh = hs_in;
      ev = vs_in;
    end
    @(posedge clock);
    #1;
    check("r", int'(r), int'(e[15:11]));
    check("g", int'(g), int'(e[10:5]));
    check("b", int'(b), int'(e[4:0]));
    check("hs", int'(hs), int'(eh));
    check("vs", int'(vs), int'(ev));
    if (!reset_n) begin
      model_reset();
    end else begin
      vs_rise = vs_in && !m_vs_last;
      hs_rise = hs_in && !m_hs_last;
      if (vs_rise) m_frames++;
`ifdef VIDEO_SCANLINE_EN
      if (vs_rise) m_par = 1'b0;
      else if (hs_rise) m_par = ~m_par;
`endif
      m_vs_last = vs_in;
      m_hs_last = hs_in;
      if (load) begin
        m_byte = bits_in;
        m_attr = attr_in;
        m_age  = 0;
      end else if (m_age < 16) begin
        m_age++;
      end
    end
  endtask

  task automatic randomize_inputs();
    load     = ($urandom_range(0, 9) == 0);
    bits_in  = 8'($urandom);
    attr_in  = 8'($urandom);
    paper_en = ($urandom_range(0, 3) != 0);
    visible  = ($urandom_range(0, 7) != 0);
    border   = 3'($urandom);
    hs_in    = ($urandom_range(0, 5) == 0);
    vs_in    = ($urandom_range(0, 40) == 0);
  endtask

  task automatic quiet(input logic [7:0] byt, input logic [7:0] att, input logic ld);
    load     = ld;
    bits_in  = byt;
    attr_in  = att;
    paper_en = 1'b1;
    visible  = 1'b1;
    border   = 3'd0;
    hs_in    = 1'b0;
    vs_in    = 1'b0;
  endtask

  initial begin
    logic [15:0] shift_pat;
    model_reset();
    reset_n = 1'b0;
    randomize_inputs();
    #1;
    check("rst_r_async", int'(r), 0);
    for (int i = 0; i < 6; i++) begin
      randomize_inputs();
      step();
    end
    quiet(8'h00, 8'h00, 1'b0);
    step();
    reset_n = 1'b1;

    // Paper shift: 1-bits black ink, 0-bits white paper, 2 clocks per pixel
    shift_pat = 16'b1100110000110011;
    quiet(8'hA5, 8'h38, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      check("shift_g", int'(g), shift_pat[15 - i] ? 0 : 'h28);
    end
    step();
    check("after16_paper", int'(r), 'h14);

    // Bright ink
    quiet(8'hFF, 8'h47, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    step();
    check("bright_r", int'(r), 'h1F);
    check("bright_g", int'(g), 'h3F);
    check("bright_b", int'(b), 'h1F);

    // Border at normal intensity
    paper_en = 1'b0;
    border   = 3'd2;
    step();
    check("border_r", int'(r), 'h14);
    check("border_g", int'(g), 0);

    // Load on a phase=1 cycle must not shift the fresh byte
    quiet(8'h80, 8'h38, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    step();
    quiet(8'h7F, 8'h38, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    step();
    check("load_prio_g", int'(g), 'h28);

    // Flash: ink white for frames 0-15, black 16-31, white from 32
    for (int f = 1; f <= 34; f++) begin
      quiet(8'h00, 8'h00, 1'b0);
      vs_in = 1'b1;
      step();
      quiet(8'hFF, 8'h87, 1'b1);
      step();
      quiet(8'h00, 8'h00, 1'b0);
      step();
      if (f == 15 || f == 16 || f == 31 || f == 32)
        check("flash_g", int'(g), ((f / 16) % 2 == 1) ? 0 : 'h28);
    end

    // Scanline dimming after one hs pulse, restored by vs
    quiet(8'h00, 8'h00, 1'b0);
    hs_in = 1'b1;
    step();
    quiet(8'hFF, 8'h07, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    step();
`ifdef VIDEO_SCANLINE_EN
    check("scan_r", int'(r), 'h0A);
    check("scan_g", int'(g), 'h14);
`else
    check("scan_r", int'(r), 'h14);
    check("scan_g", int'(g), 'h28);
`endif
    vs_in = 1'b1;
    step();
    quiet(8'hFF, 8'h07, 1'b1);
    step();
    quiet(8'h00, 8'h00, 1'b0);
    step();
    check("scan_restore_r", int'(r), 'h14);

    // Random traffic with one mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if (i == 1500) begin
        reset_n = 1'b0;
        #1;
        check("midrst_r", int'(r), 0);
        check("midrst_g", int'(g), 0);
      end
      if (i == 1503) reset_n = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/zx_pixel_colorizer.md
Name: zx_pixel_colorizer

Overview:
- Downstream stage of the VGA fetch/timing block in the zx80 project.
- Takes each fetched bitmap byte and its attribute byte, shifts pixels out at 2 VGA clocks per Spectrum pixel, and applies ink/paper/bright/flash.
- Produces final 5:6:5 RGB plus hs/vs delayed to match.
- Border and blanking are resolved here, so the timing block only supplies flags.

Parameters:
- LVL_N, 5'h14: normal-intensity level for 5-bit R/B; G uses {LVL_N,1'b0}.
- LVL_B, 5'h1F: bright-intensity level for 5-bit R/B; G uses {LVL_B,1'b1}.
- FLASH_BITS, 5: width of the frame counter; its MSB is the flash phase (toggles every 16 frames).

Ports:
- clock  in  1  pixel clock (25 MHz VGA), all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe: latch bits_in/attr_in and restart pixel phase.
- bits_in  in  8  bitmap byte, MSB leftmost.
- attr_in  in  8  attribute: [2:0] ink, [5:3] paper, [6] bright, [7] flash.
- paper_en  in  1  current clock is inside the 512x384 paper window.
- visible  in  1  current clock is inside the 640x480 active area.
- border  in  3  border colour index.
- hs_in  in  1  horizontal sync from the timing block.
- vs_in  in  1  vertical sync from the timing block.
- r  out  5  red.
- g  out  6  green.
- b  out  5  blue.
- hs  out  1  hs_in delayed 1 clock.
- vs  out  1  vs_in delayed 1 clock.

Behaviour:
- Reset (asynchronous, reset_n=0): r/g/b=0, hs=0, vs=0; shift register, attr register, phase bit, frame counter and vs/hs edge registers cleared.
- Colour index format {G,R,B}: bit0=B, bit1=R, bit2=G. Each set component outputs LVL_B if bright, else LVL_N; each clear component outputs 0.
- Shift register and phase:
  - load=1: sreg<=bits_in, areg<=attr_in, phase<=0. Load has priority over shifting in the same cycle.
  - Else if phase=1: sreg<=sreg<<1 (zero fill).
  - phase toggles every non-load cycle.
  - After 16 clocks without load, sreg is 0, so the output is paper.
- Pixel selection: pix=sreg[7]. If areg[7]=1 and flash_phase=1, ink and paper are swapped. Output colour = pix ? ink : paper, bright=areg[6].
- Output mux, registered with 1-clock latency relative to paper_en/visible/hs_in/vs_in:
  - visible=0: rgb=0.
  - visible=1 and paper_en=0: border colour at normal intensity.
  - visible=1 and paper_en=1: pixel colour.
- Frame counter: vs_prev registered. On a vs_in rising edge (vs_in=1, vs_prev=0), frame_cnt increments and wraps modulo 2^FLASH_BITS. flash_phase=frame_cnt[FLASH_BITS-1].
- hs, vs: plain 1-stage delays of hs_in, vs_in.
- Reset mid-frame: outputs go black immediately; flash restarts at phase 0.

Optional Feature:
- Macro: VIDEO_SCANLINE_EN.
- Defined:
  - A line-parity bit toggles on each hs_in rising edge and clears on each vs_in rising edge.
  - When parity=1, each RGB component is output right-shifted by 1 (MSB zero-filled).
  - Blanking is still forced to 0.
- Undefined: no parity register; all lines at full level.

Decomposition:
- Package zx_video_pkg:
  - LVL_N/LVL_B defaults.
  - ATTR_INK/PAPER/BRIGHT/FLASH bit positions.
  - Colour-index bit positions (B=0, R=1, G=2).
  - A packed rgb565 struct/typedef.
- Sub-module zx_palette (combinational): 3-bit index + bright in, 5:6:5 out. Instantiated twice (pixel colour, border colour).

Test Plan:
- Reset: reset_n=0 while clock runs with random inputs -> r=g=b=0, hs=vs=0 throughout; after release, frame_cnt=0.
- Paper shift: load bits_in=8'hA5, attr_in=8'h38 (paper 7, ink 0), paper_en=visible=1 for 16 clocks -> output pattern (1 clk later, 2 clk per pixel) is black for 1-bits, white 5'h14/6'h28/5'h14 for 0-bits: B,B,W,W,B,B,W,W,W,W,B,B,W,W,B,B.
- Bright and border:
  - attr_in=8'h47 with bits_in=8'hFF -> r=5'h1F, g=6'h3F, b=5'h1F.
  - paper_en=0, border=3'd2 -> r=5'h14, g=0, b=0.
- Flash: attr_in=8'h87 with bits_in=8'hFF -> white ink for frames 0-15, then paper (black) after the 16th vs_in rising edge, back to white after the 32nd.
- Load priority: load asserted on a phase=1 cycle -> new byte's bit7 appears next, with no shift applied to it.
- Scanline (VIDEO_SCANLINE_EN): after one hs_in pulse, a white pixel outputs r=5'h0A, g=6'h14, b=5'h0A. After a vs_in pulse, full level resumes.
